// File: rtl/period_meter.sv
// Measures the period and high time of a slow asynchronous input in system clock cycles,
// with a timeout that flags a lost input.
module period_meter #(
    parameter int unsigned MAXIMUM_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                     PM_CLOCK_IN,
    input  logic                     PM_RESET,
    input  logic                     PM_ENABLE,
    input  logic                     PM_SIGNAL_IN,
    output logic [MAXIMUM_WIDTH-1:0] PM_PERIOD_OUT,
    output logic [MAXIMUM_WIDTH-1:0] PM_HIGH_OUT,
    output logic                     PM_VALID,
    output logic                     PM_TIMEOUT
);

    typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

    localparam logic [MAXIMUM_WIDTH-1:0] TimeoutLast = MAXIMUM_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [MAXIMUM_WIDTH-1:0] One         = MAXIMUM_WIDTH'(1);
    localparam logic [MAXIMUM_WIDTH-1:0] Zero        = '0;

    state_e                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     hist_q;
    logic                     sync;
    logic                     rise;
    logic                     fall;
    logic [MAXIMUM_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [MAXIMUM_WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic                     high_latch_q, high_latch_d;
    logic [MAXIMUM_WIDTH-1:0] period_q, period_d;
    logic [MAXIMUM_WIDTH-1:0] high_q, high_d;
    logic                     valid_q, valid_d;
    logic                     timeout_q, timeout_d;

    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = sync & ~hist_q;
    assign fall = ~sync & hist_q;

    always_ff @(posedge PM_CLOCK_IN or posedge PM_RESET) begin
        if (PM_RESET) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PM_SIGNAL_IN};
            hist_q <= sync;
        end
    end

    always_ff @(posedge PM_CLOCK_IN or posedge PM_RESET) begin
        if (PM_RESET) begin
            state_q      <= StIdle;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            high_latch_q <= 1'b0;
            period_q     <= '0;
            high_q       <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            high_latch_q <= high_latch_d;
            period_q     <= period_d;
            high_q       <= high_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        high_latch_d = high_latch_q;
        period_d     = period_q;
        high_d       = high_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;

        // Disable overrides every other event, including a coincident rise or timeout.
        if (!PM_ENABLE) begin
            state_d      = StIdle;
            period_cnt_d = Zero;
            high_cnt_d   = Zero;
            high_latch_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timeout_d    = 1'b0;
                    period_cnt_d = Zero;
                    high_cnt_d   = Zero;
                    high_latch_d = 1'b0;
                    state_d      = StArm;
                end
                StArm: begin
                    if (rise) begin
                        period_cnt_d = Zero;
                        high_cnt_d   = Zero;
                        high_latch_d = 1'b1;
                        state_d      = StMeasure;
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        period_d     = period_cnt_q + One;
                        high_d       = high_cnt_q + MAXIMUM_WIDTH'(high_latch_q & ~fall);
                        valid_d      = 1'b1;
                        timeout_d    = 1'b0;
                        period_cnt_d = Zero;
                        high_cnt_d   = Zero;
                        high_latch_d = 1'b1;
                    end else if (period_cnt_q == TimeoutLast) begin
                        timeout_d = 1'b1;
                        state_d   = StArm;
                    end else begin
                        period_cnt_d = period_cnt_q + One;
                        // The cycle that sees the fall still counts as high.
                        if (high_latch_q) begin
                            high_cnt_d = high_cnt_q + One;
                        end
                        if (fall) begin
                            high_latch_d = 1'b0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign PM_PERIOD_OUT = period_q;
    assign PM_HIGH_OUT   = high_q;
    assign PM_VALID      = valid_q;
    assign PM_TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed and random waveforms checked against an edge-time model.
module tb_period_meter;

    localparam int unsigned Timeout = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        sig = 1'b0;
    logic [31:0] period_out;
    logic [31:0] high_out;
    logic        valid;
    logic        timeout;

    period_meter #(
        .MAXIMUM_WIDTH (32),
        .TIMEOUT_CYCLES(Timeout),
        .SYNC_STAGES   (2)
    ) dut (
        .PM_CLOCK_IN  (clk),
        .PM_RESET     (rst),
        .PM_ENABLE    (en),
        .PM_SIGNAL_IN (sig),
        .PM_PERIOD_OUT(period_out),
        .PM_HIGH_OUT  (high_out),
        .PM_VALID     (valid),
        .PM_TIMEOUT   (timeout)
    );

    always #10 clk = ~clk;

    typedef struct {
        int unsigned period;
        int unsigned high;
        int unsigned cyc;
    } res_t;

    res_t        obs[$];
    res_t        exp_q[$];
    res_t        seen[$];
    int unsigned cyc = 0;
    int unsigned last_valid_cyc = 0;
    int unsigned to_rise_cyc = 0;
    int unsigned to_fall_cyc = 0;
    int unsigned to_rise_cnt = 0;
    logic        prev_to = 1'b0;
    int          checks = 0;
    int          fails = 0;

    // Reference model state, in driver cycles: time of last rise/fall and whether a rise is held.
    int unsigned t = 0;
    int unsigned last_rise = 0;
    int unsigned last_fall = 0;
    bit          meas = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            obs.push_back('{period: period_out, high: high_out, cyc: cyc});
            last_valid_cyc = cyc;
        end
        if (timeout && !prev_to) begin
            to_rise_cyc = cyc;
            to_rise_cnt++;
        end
        if (!timeout && prev_to) to_fall_cyc = cyc;
        prev_to = timeout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Rises closer than or equal to the timeout apart yield a result; a longer gap just re-arms.
    task automatic hold(input logic v, input int unsigned n);
        if (v && !sig && en) begin
            if (meas && (t - last_rise) <= Timeout)
                exp_q.push_back('{period: t - last_rise, high: last_fall - last_rise, cyc: 0});
            meas      = 1'b1;
            last_rise = t;
        end
        if (!v && sig) last_fall = t;
        sig = v;
        repeat (n) @(posedge clk);
        #1;
        t += n;
    endtask

    task automatic set_en(input logic v);
        en = v;
        if (!v) meas = 1'b0;
    endtask

    task automatic compare(input string tag);
        check({tag, " count"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            check({tag, " period"}, obs[i].period, exp_q[i].period);
            check({tag, " high"}, obs[i].high, exp_q[i].high);
        end
        seen = obs;
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        int unsigned snap;
        int unsigned h;
        int unsigned l;

        #2 rst = 1'b1;
        #5;
        check("reset period", period_out, 0);
        check("reset high", high_out, 0);
        check("reset valid", {31'b0, valid}, 0);
        check("reset timeout", {31'b0, timeout}, 0);
        repeat (3) @(posedge clk);
        #5 rst = 1'b0;
        @(posedge clk);
        #1;

        // Square wave 250/250
        set_en(1'b1);
        hold(1'b0, 10);
        repeat (4) begin
            hold(1'b1, 250);
            hold(1'b0, 250);
        end
        compare("square");

        // Duty change 100/300
        repeat (3) begin
            hold(1'b1, 100);
            hold(1'b0, 300);
        end
        compare("duty");

        // Minimum period 2
        repeat (10) begin
            hold(1'b1, 1);
            hold(1'b0, 1);
        end
        hold(1'b0, 10);
        compare("period2");
        for (int i = 2; i < seen.size(); i++)
            check("period2 spacing", seen[i].cyc - seen[i-1].cyc, 2);

        // Input stops low after 500-cycle results
        repeat (3) begin
            hold(1'b1, 250);
            hold(1'b0, 250);
        end
        hold(1'b1, 250);
        hold(1'b0, 1200);
        compare("pre-timeout");
        check("timeout level", {31'b0, timeout}, 1);
        check("timeout period held", period_out, 500);
        check("timeout high held", high_out, 250);
        check("timeout delay", to_rise_cyc - last_valid_cyc, Timeout);

        // Restart at period 300
        repeat (3) begin
            hold(1'b1, 150);
            hold(1'b0, 150);
        end
        compare("restart");
        if (seen.size() > 0) check("timeout clears with valid", to_fall_cyc, seen[0].cyc);
        check("timeout cleared", {31'b0, timeout}, 0);

        // Disable while timed out, then re-enable
        hold(1'b1, 150);
        hold(1'b0, 1200);
        compare("second timeout");
        check("second timeout level", {31'b0, timeout}, 1);
        set_en(1'b0);
        hold(1'b0, 20);
        hold(1'b1, 50);
        hold(1'b0, 50);
        compare("disabled");
        check("disabled timeout held", {31'b0, timeout}, 1);
        check("disabled period held", period_out, 300);
        set_en(1'b1);
        hold(1'b0, 10);
        check("re-enable timeout", {31'b0, timeout}, 0);
        hold(1'b1, 60);
        hold(1'b0, 60);
        compare("re-enable one rise");
        hold(1'b1, 60);
        hold(1'b0, 20);
        set_en(1'b0);
        hold(1'b0, 40);
        hold(1'b1, 60);
        hold(1'b0, 60);
        compare("disable mid-period");
        check("mid-disable period held", period_out, 120);
        check("mid-disable high held", high_out, 60);
        set_en(1'b1);
        hold(1'b0, 10);

        // Period exactly equal to the timeout: rise wins
        snap = to_rise_cnt;
        repeat (3) begin
            hold(1'b1, 500);
            hold(1'b0, 500);
        end
        hold(1'b1, 10);
        hold(1'b0, 20);
        compare("rise vs timeout");
        check("no timeout at boundary", to_rise_cnt, snap);
        check("boundary timeout level", {31'b0, timeout}, 0);

        // Random waveforms, some gaps straddling the timeout
        repeat (20) begin
            h = $urandom_range(1, 40);
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(900, 1100) : $urandom_range(1, 40);
            hold(1'b1, h);
            hold(1'b0, l);
        end
        hold(1'b1, 30);
        hold(1'b0, 1200);
        compare("random");
        check("random end timeout", {31'b0, timeout}, 1);

        // Asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        check("async reset period", period_out, 0);
        check("async reset high", high_out, 0);
        check("async reset valid", {31'b0, valid}, 0);
        check("async reset timeout", {31'b0, timeout}, 0);
        meas = 1'b0;
        repeat (2) @(posedge clk);
        #5 rst = 1'b0;
        @(posedge clk);
        #1;
        hold(1'b0, 10);
        hold(1'b1, 40);
        hold(1'b0, 40);
        compare("post-reset first edges");
        hold(1'b1, 40);
        hold(1'b0, 40);
        compare("post-reset result");
        check("post-reset timeout", {31'b0, timeout}, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
